neopixel_strand_receiver: RTL and testbench

Decodes the single-wire NeoPixel waveform produced by the team's strand controller (50 MHz clock) back into per-pixel G/R/B bytes. The block sits at the far end of `neo_data`, either as a loopback checker for the strand controller or as a front end for a downstream pixel sink. It measures each high-pulse width to classify bits, assembles 24-bit pixel words, and detects the inter-frame low gap as end-of-frame. It flags malformed pulses and partial pixels.

---
 rtl/neopixel_strand_receiver.sv | 189 ++++++++++++++++++
 tb/tb_neopixel_strand_receiver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_strand_receiver.sv
// NeoPixel single-wire receiver: measures high-pulse widths to classify bits,
// assembles 24-bit {G,R,B} pixel words (LSB-first over the packet), and treats
// a long low gap as end-of-frame. Malformed pulses and partial pixels raise
// bit_error.
module neopixel_strand_receiver #(
    parameter int NUM_PIXELS  = 5,
    parameter int HIGH_THRESH = 27,
    parameter int MIN_HIGH    = 8,
    parameter int MAX_HIGH    = 60,
    parameter int MAX_LOW     = 100,
    parameter int GAP_CYCLES  = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       neo_data,
    output logic       pixel_valid,
    output logic [2:0] pixel_index,
    output logic [7:0] green,
    output logic [7:0] red,
    output logic [7:0] blue,
    output logic       frame_done,
    output logic [3:0] frame_pixels,
    output logic       bit_error,
    output logic       busy
);

    // Sized copies of the thresholds so every compare is width-matched.
    localparam logic [6:0]  HIGH_THRESH_C = 7'(HIGH_THRESH);
    localparam logic [6:0]  MIN_HIGH_C    = 7'(MIN_HIGH);
    localparam logic [6:0]  MAX_HIGH_C    = 7'(MAX_HIGH);
    localparam logic [11:0] MAX_LOW_C     = 12'(MAX_LOW);
    localparam logic [11:0] GAP_C         = 12'(GAP_CYCLES);
    localparam logic [3:0]  NUM_PIXELS_C  = 4'(NUM_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_ERR
    } state_t;

    state_t      state_reg;
    logic        s_reg;
    logic        p_reg;
    logic [6:0]  high_cnt_reg;
    logic [11:0] low_cnt_reg;
    logic [4:0]  bit_cnt_reg;
    logic [3:0]  pix_cnt_reg;
    // Only the 23 most recent bits need keeping; the 24th arrives live.
    logic [22:0] acc_reg;

    logic        rise;
    logic        fall;
    logic        bit_val;
    logic [23:0] word_next;
    logic [3:0]  pix_cnt_next;
    logic [11:0] low_cnt_next;
    logic [6:0]  high_cnt_next;
    logic        gap_reached;

    // Edge detection, bit classification and saturating counter increments.
    always_comb begin
        rise          = s_reg & ~p_reg;
        fall          = ~s_reg & p_reg;
        bit_val       = (high_cnt_reg >= HIGH_THRESH_C);
        word_next     = {bit_val, acc_reg};
        pix_cnt_next  = (pix_cnt_reg == 4'd15) ? pix_cnt_reg : pix_cnt_reg + 4'd1;
        low_cnt_next  = (low_cnt_reg == GAP_C) ? low_cnt_reg : low_cnt_reg + 12'd1;
        high_cnt_next = (high_cnt_reg == 7'h7F) ? high_cnt_reg : high_cnt_reg + 7'd1;
        gap_reached   = ((state_reg == ST_LOW) || (state_reg == ST_ERR)) && (low_cnt_reg == GAP_C);
    end

    // Input sampling, decode state machine and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            s_reg        <= 1'b0;
            p_reg        <= 1'b0;
            high_cnt_reg <= '0;
            low_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            pix_cnt_reg  <= '0;
            acc_reg      <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            green        <= '0;
            red          <= '0;
            blue         <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            bit_error    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            s_reg       <= neo_data;
            p_reg       <= s_reg;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;

            if (gap_reached) begin
                // End of frame; leftover bits mean a partial pixel.
                frame_done   <= 1'b1;
                frame_pixels <= pix_cnt_reg;
                bit_error    <= (bit_cnt_reg != 5'd0);
                pix_cnt_reg  <= '0;
                bit_cnt_reg  <= '0;
                low_cnt_reg  <= '0;
                if (rise) begin
                    // A new frame starting right at the gap is not lost.
                    state_reg    <= ST_HIGH;
                    high_cnt_reg <= 7'd1;
                    busy         <= 1'b1;
                end else begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rise) begin
                            state_reg    <= ST_HIGH;
                            high_cnt_reg <= 7'd1;
                            busy         <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            if ((high_cnt_reg < MIN_HIGH_C) || (high_cnt_reg > MAX_HIGH_C)) begin
                                state_reg   <= ST_ERR;
                                bit_error   <= 1'b1;
                                low_cnt_reg <= 12'd1;
                                bit_cnt_reg <= '0;
                            end else begin
                                state_reg   <= ST_LOW;
                                low_cnt_reg <= 12'd1;
                                acc_reg     <= word_next[23:1];
                                if (bit_cnt_reg == 5'd23) begin
                                    if (pix_cnt_reg < NUM_PIXELS_C) begin
                                        pixel_valid <= 1'b1;
                                        pixel_index <= pix_cnt_reg[2:0];
                                        green       <= word_next[23:16];
                                        red         <= word_next[15:8];
                                        blue        <= word_next[7:0];
                                    end
                                    pix_cnt_reg <= pix_cnt_next;
                                    bit_cnt_reg <= '0;
                                end else begin
                                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                                end
                            end
                        end else if (high_cnt_reg == MAX_HIGH_C) begin
                            // Pulse is about to exceed the longest legal width.
                            state_reg   <= ST_ERR;
                            bit_error   <= 1'b1;
                            low_cnt_reg <= '0;
                            bit_cnt_reg <= '0;
                        end else begin
                            high_cnt_reg <= high_cnt_next;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            if (low_cnt_reg <= MAX_LOW_C) begin
                                state_reg    <= ST_HIGH;
                                high_cnt_reg <= 7'd1;
                            end else begin
                                state_reg   <= ST_ERR;
                                bit_error   <= 1'b1;
                                low_cnt_reg <= '0;
                                bit_cnt_reg <= '0;
                            end
                        end else begin
                            low_cnt_reg <= low_cnt_next;
                        end
                    end
                    default: begin
                        // Error recovery: any high restarts the gap measurement.
                        if (s_reg) begin
                            low_cnt_reg <= '0;
                        end else begin
                            low_cnt_reg <= low_cnt_next;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neopixel_strand_receiver.sv
// Scoreboard bench for neopixel_strand_receiver: stimulus pushes expected
// pixels/frames/errors into queues, a negedge monitor pops and compares.
module tb_neopixel_strand_receiver;

    logic       clock;
    logic       reset;
    logic       neo_data;
    logic       pixel_valid;
    logic [2:0] pixel_index;
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
    logic       frame_done;
    logic [3:0] frame_pixels;
    logic       bit_error;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pix_t;

    typedef struct {
        logic [3:0] n;
        logic       err;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    int   err_expected = 0;

    neopixel_strand_receiver dut (
        .clock        (clock),
        .reset        (reset),
        .neo_data     (neo_data),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .green        (green),
        .red          (red),
        .blue         (blue),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_error    (bit_error),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #50ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: one line per observed transaction.
    pix_t pe;
    frm_t fe;
    always @(negedge clock) begin
        if (pixel_valid) begin
            checks++;
            if (pix_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pixel: got idx=%0d G=%02h R=%02h B=%02h, none expected",
                         pixel_index, green, red, blue);
            end else begin
                pe = pix_q.pop_front();
                if (pixel_index !== pe.idx || green !== pe.g || red !== pe.r || blue !== pe.b) begin
                    fails++;
                    $display("FAIL pixel: got idx=%0d G=%02h R=%02h B=%02h, expected idx=%0d G=%02h R=%02h B=%02h",
                             pixel_index, green, red, blue, pe.idx, pe.g, pe.r, pe.b);
                end else begin
                    $display("pixel idx=%0d G=%02h R=%02h B=%02h ok", pixel_index, green, red, blue);
                end
            end
        end
        if (frame_done) begin
            checks++;
            if (frm_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_frame: got frame_pixels=%0d bit_error=%0b, none expected",
                         frame_pixels, bit_error);
            end else begin
                fe = frm_q.pop_front();
                if (frame_pixels !== fe.n || bit_error !== fe.err || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL frame: got frame_pixels=%0d bit_error=%0b busy=%0b, expected frame_pixels=%0d bit_error=%0b busy=0",
                             frame_pixels, bit_error, busy, fe.n, fe.err);
                end else begin
                    $display("frame_done frame_pixels=%0d bit_error=%0b ok", frame_pixels, bit_error);
                end
            end
        end else if (bit_error) begin
            checks++;
            if (err_expected == 0) begin
                fails++;
                $display("FAIL unexpected_bit_error: got bit_error=1, expected 0");
            end else begin
                err_expected--;
                $display("bit_error pulse ok");
            end
        end
    end

    task automatic send_bit(input logic b);
        neo_data = 1'b1;
        repeat (b ? 36 : 19) @(negedge clock);
        neo_data = 1'b0;
        repeat (b ? 30 : 40) @(negedge clock);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    task automatic gap(input int n);
        neo_data = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_pixel(input int idx, input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        pix_t p;
        p.idx = 3'(idx);
        p.g = g;
        p.r = r;
        p.b = b;
        pix_q.push_back(p);
    endtask

    task automatic expect_frame(input int n, input logic err);
        frm_t f;
        f.n = 4'(n);
        f.err = err;
        frm_q.push_back(f);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (pixel_valid !== 1'b0 || pixel_index !== 3'd0 || green !== 8'd0 || red !== 8'd0 ||
            blue !== 8'd0 || frame_done !== 1'b0 || frame_pixels !== 4'd0 ||
            bit_error !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: got pv=%0b idx=%0d G=%02h R=%02h B=%02h fd=%0b fp=%0d be=%0b busy=%0b, expected all 0",
                     name, pixel_valid, pixel_index, green, red, blue, frame_done, frame_pixels, bit_error, busy);
        end else begin
            $display("%s outputs all zero ok", name);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            neo_data = ~neo_data;
            check_outputs_zero(name);
        end
        neo_data = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic [23:0] w;

    initial begin
        reset    = 1'b0;
        neo_data = 1'b0;

        // Reset with the line toggling, then a long idle line.
        do_reset("reset");
        gap(3000);

        // Single pixel.
        expect_pixel(0, 8'hA5, 8'h3C, 8'h81);
        expect_frame(1, 1'b0);
        send_bits(24'hA53C81, 24);
        gap(2500);

        // Five-pixel frame as produced by the strand controller.
        for (int k = 0; k < 5; k++) expect_pixel(k, 8'(k), 8'(8'h10 + k), 8'(8'hF0 - k));
        expect_frame(5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            w = {8'(k), 8'(8'h10 + k), 8'(8'hF0 - k)};
            send_bits(w, 24);
        end
        gap(2500);

        // Glitch after 10 bits: error, rest of frame discarded.
        err_expected++;
        expect_frame(0, 1'b0);
        w = 24'h5A_C3_18;
        send_bits(w, 10);
        neo_data = 1'b1;
        repeat (4) @(negedge clock);
        neo_data = 1'b0;
        repeat (40) @(negedge clock);
        for (int i = 10; i < 24; i++) send_bit(w[i]);
        send_bits(24'hFFFFFF, 24);
        gap(2500);

        // Partial pixel: 30 bits.
        expect_pixel(0, 8'h12, 8'h34, 8'h56);
        expect_frame(1, 1'b1);
        send_bits(24'h123456, 24);
        send_bits(24'h00002D, 6);
        gap(2500);

        // Overflow: 7 pixels, only 5 output.
        for (int k = 0; k < 5; k++) expect_pixel(k, 8'(8'h80 + k), 8'(8'h0F ^ k), 8'(8'h55 + 3 * k));
        expect_frame(7, 1'b0);
        for (int k = 0; k < 7; k++) begin
            w = {8'(8'h80 + k), 8'(8'h0F ^ k), 8'(8'h55 + 3 * k)};
            send_bits(w, 24);
        end
        gap(2500);

        // Mid-frame reset during bit 12 of pixel 2.
        expect_pixel(0, 8'h11, 8'h22, 8'h33);
        expect_pixel(1, 8'h44, 8'h55, 8'h66);
        send_bits(24'h112233, 24);
        send_bits(24'h445566, 24);
        send_bits(24'hFFFFFF, 12);
        neo_data = 1'b1;
        repeat (10) @(negedge clock);
        do_reset("midframe_reset");
        gap(3000);
        expect_pixel(0, 8'hC7, 8'h01, 8'hFE);
        expect_frame(1, 1'b0);
        send_bits(24'hC701FE, 24);
        gap(2500);

        // Drain: every expected transaction must have appeared.
        for (int i = 0; i < 5000; i++) begin
            if (pix_q.size() == 0 && frm_q.size() == 0 && err_expected == 0) break;
            @(negedge clock);
        end
        checks++;
        if (pix_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pixels: got %0d still pending, expected 0", pix_q.size());
        end
        checks++;
        if (frm_q.size() != 0) begin
            fails++;
            $display("FAIL missing_frames: got %0d still pending, expected 0", frm_q.size());
        end
        checks++;
        if (err_expected != 0) begin
            fails++;
            $display("FAIL missing_bit_error: got %0d still pending, expected 0", err_expected);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL final_busy: got %0b, expected 0", busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
